multicycle_ctrl_fsm: RTL and testbench
======================================

# multicycle_ctrl_fsm

Control sequencer for the simplified multicycle 16-bit RISC-V processor. Drives the clock-enable inputs of the datapath's enable registers (PC, IR, A/B operand, ALU-out, MDR), the register-file write strobe and the memory read/write strobes. One instruction takes 3–5 states. Instruction class comes from the separate decoder, and memory accesses use a ready handshake with a watchdog timeout.

## Interface
- `TIMEOUT_CYCLES`, default 15: number of consecutive `mem_ready`-low cycles in FETCH/MEM before abort. 0 disables the watchdog.
- `clk_n`  in  1  clock; all state updates on the negedge of `clk_n`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op_class`  in  3  decoder class:
  - 0 ALU-R, 1 ALU-I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JUMP, 6 HALT, 7 illegal.
- `branch_taken`  in  1  ALU compare result; valid in EXEC.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `pc_en`, `ir_en`, `ab_en`, `aluo_en`, `mdr_en`  out  1 each  register clock enables.
- `rf_we`  out  1  register-file write.
- `mem_re`, `mem_we`  out  1 each  memory strobes.
- `pc_sel`  out  2  PC source: 0 PC+2, 1 branch target, 2 jump target.
- `wb_sel`  out  2  write-back source: 0 ALU-out, 1 MDR, 2 PC (link).
- `alu_src_imm`  out  1  ALU B operand = immediate.
- `state`  out  3  current state, for debug.
- `bus_err`  out  1  one-cycle pulse on watchdog abort.
- `halted`  out  1  high in HALT.
- `trap`  out  1  high in TRAP. Only present with `CTRL_ILLEGAL_TRAP_EN`.

## Operation
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, TRAP=6.
- Internal `cls` register latches `op_class` in DECODE. EXEC, MEM and WB use `cls` only.
- Outputs are combinational from state, `cls` and inputs. Every output is forced to 0 while `rst_n`=0.
- FETCH:
  - `mem_re`=1.
  - On `mem_ready`=1: `ir_en`=1, `pc_en`=1, `pc_sel`=0, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - `ab_en`=1.
  - Next state: HALT if `op_class`=6; class 7 see Configuration; else EXEC.
- EXEC:
  - `alu_src_imm`=1 for classes 1, 2, 3.
  - `aluo_en`=1 for classes 0–3.
  - BRANCH: `pc_sel`=1, `pc_en`=`branch_taken`, next state FETCH.
  - JUMP: `pc_sel`=2, `pc_en`=1, next state WB.
  - Classes 0, 1: next state WB.
  - Classes 2, 3: next state MEM.
- MEM:
  - LOAD: `mem_re`=1. On `mem_ready`: `mdr_en`=1, next state WB.
  - STORE: `mem_we`=1. On `mem_ready`: next state FETCH.
- WB:
  - `rf_we`=1.
  - `wb_sel`=1 for LOAD, 2 for JUMP, 0 otherwise.
  - Next state FETCH.
- HALT: all enables 0, `halted`=1. Exit only by reset.
- Watchdog:
  - 4-bit-minimum counter (`$clog2(TIMEOUT_CYCLES+1)` bits).
  - Increments each cycle in FETCH/MEM with `mem_ready`=0.
  - Clears on any state change or `mem_ready`=1.
  - In the cycle the count equals `TIMEOUT_CYCLES`-1 with `mem_ready`=0: `bus_err`=1, all strobes and enables 0, next state FETCH, counter cleared.
  - PC is not advanced, so FETCH retries the same address.
  - A MEM timeout abandons the instruction with no RF/MDR write.
- `mem_ready`=1 in the same cycle as the timeout condition: ready wins, no `bus_err`.
- `mem_ready` is ignored outside FETCH/MEM.

## Timing
- Reset:
  - `state`=FETCH, `cls`=0, counter=0, all outputs 0.
  - The first negedge after `rst_n` rises is evaluated in FETCH with `mem_re`=1.
- Latency with zero-wait memory (`mem_ready` held high), in `clk_n` cycles:
  - ALU-R/ALU-I 4, LOAD 5, STORE 4, BRANCH 3, JUMP 4.
  - Each wait cycle adds 1.
- Enables are valid for the full cycle and consumed by the datapath registers at the same negedge that advances `state`.
- Reset mid-instruction aborts immediately, and no further enables are asserted.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined:
  - DECODE with `op_class`=7 goes to TRAP: `trap`=1, all enables 0, exit only by reset.
  - The `trap` port exists.
- Not defined:
  - `op_class`=7 goes from DECODE directly to FETCH as a NOP (PC already advanced).
  - No `trap` port and no TRAP state.

## Test plan
- ALU-R, `op_class`=0, `mem_ready`=1:
  - `state` runs 0→1→2→4→0 over 4 cycles.
  - `rf_we`=1 only in cycle 4, with `wb_sel`=0.
- LOAD, `op_class`=2, with `mem_ready` low for 2 cycles in MEM:
  - 7 cycles total.
  - `mdr_en`=1 exactly once.
  - WB has `wb_sel`=1.
- BRANCH, `op_class`=4:
  - `branch_taken`=0: `pc_en`=0 in EXEC.
  - `branch_taken`=1: `pc_en`=1 and `pc_sel`=1 in EXEC.
  - Both return to FETCH after 3 cycles.
- `TIMEOUT_CYCLES`=3, `mem_ready` held 0 in FETCH:
  - `bus_err` pulses in the 3rd cycle.
  - Retries repeat every 3 cycles with `ir_en`, `pc_en` never asserted.
- `op_class`=6: `halted`=1 and state 5 persists for 20 cycles; `rst_n` low returns all outputs to 0.
- `op_class`=7:
  - With the macro: state 6, `trap`=1.
  - Without: DECODE→FETCH and no write strobes.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_fsm
//
// Control sequencer for the multicycle 16-bit RISC-V datapath. It steps each
// instruction through FETCH / DECODE / EXEC / MEM / WB and drives the datapath
// register clock enables, the register-file write strobe and the memory
// strobes. Memory accesses (FETCH and MEM) wait on mem_ready, and a watchdog
// abandons an access that stays unready for TIMEOUT_CYCLES cycles.
//
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN
//   defined   : op_class 7 in DECODE enters TRAP (sticky until reset); trap port exists
//   undefined : op_class 7 is a NOP (DECODE -> FETCH); no trap port, no TRAP state
//
// Parameters
//   TIMEOUT_CYCLES  consecutive mem_ready-low cycles before abort (0 = no watchdog)
//
// Ports
//   clk_n         in   clock, all state updates on its falling edge
//   rst_n         in   asynchronous active-low reset
//   op_class[2:0] in   decoder class (0 ALU-R, 1 ALU-I, 2 LOAD, 3 STORE,
//                      4 BRANCH, 5 JUMP, 6 HALT, 7 illegal)
//   branch_taken  in   ALU compare result, used in EXEC
//   mem_ready     in   memory completes the current access this cycle
//   pc_en, ir_en, ab_en, aluo_en, mdr_en
//                 out  datapath register clock enables
//   rf_we         out  register-file write
//   mem_re/mem_we out  memory read / write strobes
//   pc_sel[1:0]   out  PC source: 0 PC+2, 1 branch target, 2 jump target
//   wb_sel[1:0]   out  write-back source: 0 ALU-out, 1 MDR, 2 PC (link)
//   alu_src_imm   out  ALU B operand is the immediate
//   state[2:0]    out  current state (debug)
//   bus_err       out  one-cycle pulse on watchdog abort
//   halted        out  high in HALT
//   trap          out  high in TRAP (only with CTRL_ILLEGAL_TRAP_EN)
// -----------------------------------------------------------------------------
// state  | meaning
// FETCH  | read instruction; on ready load IR and advance PC by 2
// DECODE | load A/B operands, latch op_class into cls
// EXEC   | ALU operation, branch/jump PC update
// MEM    | data load (into MDR) or store
// WB     | register-file write from ALU-out, MDR or link PC
// HALT   | idle, halted=1, left only by reset
// TRAP   | illegal instruction, trap=1, left only by reset
// -----------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic       clk_n,
  input  logic       rst_n,
  input  logic [2:0] op_class,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       ir_en,
  output logic       ab_en,
  output logic       aluo_en,
  output logic       mdr_en,
  output logic       rf_we,
  output logic       mem_re,
  output logic       mem_we,
  output logic [1:0] pc_sel,
  output logic [1:0] wb_sel,
  output logic       alu_src_imm,
  output logic [2:0] state,
  output logic       bus_err,
  output logic       halted
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic       trap
`endif
);

  localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W   = (CNT_RAW < 4) ? 4 : CNT_RAW;
  localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
  // Abort fires while the count of earlier unready cycles equals TIMEOUT-1,
  // i.e. on the TIMEOUT-th consecutive unready cycle.
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] C_ALU_R   = 3'd0;
  localparam logic [2:0] C_ALU_I   = 3'd1;
  localparam logic [2:0] C_LOAD    = 3'd2;
  localparam logic [2:0] C_STORE   = 3'd3;
  localparam logic [2:0] C_BRANCH  = 3'd4;
  localparam logic [2:0] C_JUMP    = 3'd5;
  localparam logic [2:0] C_HALT    = 3'd6;
  localparam logic [2:0] C_ILLEGAL = 3'd7;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    S_TRAP   = 3'd6
`endif
  } state_t;

  state_t           cur_state;
  state_t           nxt_state;
  logic [2:0]       cls;
  logic [CNT_W-1:0] wd_cnt;
  logic             wait_st;
  logic             wd_abort;

  // Unready cycle in a state that owns a memory access.
  assign wait_st  = ((cur_state == S_FETCH) || (cur_state == S_MEM)) && !mem_ready;
  assign wd_abort = WD_EN && wait_st && (wd_cnt == CNT_LAST);

  always_ff @(negedge clk_n or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= S_FETCH;
      cls       <= '0;
      wd_cnt    <= '0;
    end else begin
      cur_state <= nxt_state;
      if (cur_state == S_DECODE) begin
        cls <= op_class;
      end
      // Counter only survives a cycle that stays put waiting on memory.
      if (wait_st && !wd_abort && (nxt_state == cur_state)) begin
        wd_cnt <= wd_cnt + 1'b1;
      end else begin
        wd_cnt <= '0;
      end
    end
  end

  always_comb begin
    nxt_state   = cur_state;
    pc_en       = 1'b0;
    ir_en       = 1'b0;
    ab_en       = 1'b0;
    aluo_en     = 1'b0;
    mdr_en      = 1'b0;
    rf_we       = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    pc_sel      = 2'd0;
    wb_sel      = 2'd0;
    alu_src_imm = 1'b0;
    bus_err     = 1'b0;
    halted      = 1'b0;
    state       = cur_state;
`ifdef CTRL_ILLEGAL_TRAP_EN
    trap        = 1'b0;
`endif

    case (cur_state)
      S_FETCH: begin
        if (mem_ready) begin
          mem_re    = 1'b1;
          ir_en     = 1'b1;
          pc_en     = 1'b1;
          pc_sel    = 2'd0;
          nxt_state = S_DECODE;
        end else if (wd_abort) begin
          // Strobes dropped, PC untouched: the retry refetches the same address.
          bus_err   = 1'b1;
          nxt_state = S_FETCH;
        end else begin
          mem_re = 1'b1;
        end
      end

      S_DECODE: begin
        ab_en = 1'b1;
        if (op_class == C_HALT) begin
          nxt_state = S_HALT;
        end else if (op_class == C_ILLEGAL) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          nxt_state = S_TRAP;
`else
          // NOP: PC was already advanced in FETCH.
          nxt_state = S_FETCH;
`endif
        end else begin
          nxt_state = S_EXEC;
        end
      end

      S_EXEC: begin
        alu_src_imm = (cls == C_ALU_I) || (cls == C_LOAD) || (cls == C_STORE);
        aluo_en     = (cls <= C_STORE);
        case (cls)
          C_ALU_R, C_ALU_I: nxt_state = S_WB;
          C_LOAD, C_STORE:  nxt_state = S_MEM;
          C_BRANCH: begin
            pc_sel    = 2'd1;
            pc_en     = branch_taken;
            nxt_state = S_FETCH;
          end
          C_JUMP: begin
            pc_sel    = 2'd2;
            pc_en     = 1'b1;
            nxt_state = S_WB;
          end
          default: nxt_state = S_FETCH;
        endcase
      end

      S_MEM: begin
        if ((cls == C_LOAD) || (cls == C_STORE)) begin
          if (mem_ready) begin
            mem_re    = (cls == C_LOAD);
            mem_we    = (cls == C_STORE);
            mdr_en    = (cls == C_LOAD);
            nxt_state = (cls == C_LOAD) ? S_WB : S_FETCH;
          end else if (wd_abort) begin
            // Instruction abandoned: no MDR load, no write-back.
            bus_err   = 1'b1;
            nxt_state = S_FETCH;
          end else begin
            mem_re = (cls == C_LOAD);
            mem_we = (cls == C_STORE);
          end
        end else begin
          nxt_state = S_FETCH;
        end
      end

      S_WB: begin
        rf_we = 1'b1;
        if (cls == C_LOAD) begin
          wb_sel = 2'd1;
        end else if (cls == C_JUMP) begin
          wb_sel = 2'd2;
        end else begin
          wb_sel = 2'd0;
        end
        nxt_state = S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
      end

`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP: begin
        trap = 1'b1;
      end
`endif

      default: begin
        nxt_state = S_FETCH;
      end
    endcase

    // Outputs are combinational, so hold them all low while reset is asserted.
    if (!rst_n) begin
      pc_en       = 1'b0;
      ir_en       = 1'b0;
      ab_en       = 1'b0;
      aluo_en     = 1'b0;
      mdr_en      = 1'b0;
      rf_we       = 1'b0;
      mem_re      = 1'b0;
      mem_we      = 1'b0;
      pc_sel      = 2'd0;
      wb_sel      = 2'd0;
      alu_src_imm = 1'b0;
      bus_err     = 1'b0;
      halted      = 1'b0;
      state       = 3'd0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      trap        = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm
//
// Two instances of multicycle_ctrl_fsm (default watchdog of 15 cycles and a
// short one of 3) share their inputs. Each is compared every cycle against a
// reference model that walks the per-class route of phases
// (e.g. LOAD = F D E M W) and derives the strobes from the phase and class.
// Directed instruction runs check latencies and the corner cases, then a
// randomized run exercises arbitrary class / ready / reset mixes.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;

  localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4, P_H = 5, P_T = 6;

  typedef struct packed {
    logic       pc_en;
    logic       ir_en;
    logic       ab_en;
    logic       aluo_en;
    logic       mdr_en;
    logic       rf_we;
    logic       mem_re;
    logic       mem_we;
    logic [1:0] pc_sel;
    logic [1:0] wb_sel;
    logic       alu_src_imm;
    logic       bus_err;
    logic       halted;
    logic       trap;
    logic [2:0] state;
  } obs_t;

  typedef struct {
    int idx;    // position along the route of the current instruction
    int cls;    // class latched at decode
    int waits;  // consecutive unready cycles so far in this access
  } mdl_t;

  logic       clk_n;
  logic       rst_n;
  logic [2:0] op_class;
  logic       branch_taken;
  logic       mem_ready;

  logic       pc_en15, ir_en15, ab_en15, aluo_en15, mdr_en15, rf_we15, mem_re15, mem_we15;
  logic [1:0] pc_sel15, wb_sel15;
  logic       alu_src_imm15, bus_err15, halted15;
  logic [2:0] state15;
  logic       pc_en3, ir_en3, ab_en3, aluo_en3, mdr_en3, rf_we3, mem_re3, mem_we3;
  logic [1:0] pc_sel3, wb_sel3;
  logic       alu_src_imm3, bus_err3, halted3;
  logic [2:0] state3;
  logic       trap15, trap3;

  multicycle_ctrl_fsm dut15 (
    .clk_n(clk_n), .rst_n(rst_n), .op_class(op_class), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .pc_en(pc_en15), .ir_en(ir_en15), .ab_en(ab_en15),
    .aluo_en(aluo_en15), .mdr_en(mdr_en15), .rf_we(rf_we15), .mem_re(mem_re15),
    .mem_we(mem_we15), .pc_sel(pc_sel15), .wb_sel(wb_sel15), .alu_src_imm(alu_src_imm15),
    .state(state15), .bus_err(bus_err15), .halted(halted15)
`ifdef CTRL_ILLEGAL_TRAP_EN
    , .trap(trap15)
`endif
  );

  multicycle_ctrl_fsm #(.TIMEOUT_CYCLES(3)) dut3 (
    .clk_n(clk_n), .rst_n(rst_n), .op_class(op_class), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .pc_en(pc_en3), .ir_en(ir_en3), .ab_en(ab_en3),
    .aluo_en(aluo_en3), .mdr_en(mdr_en3), .rf_we(rf_we3), .mem_re(mem_re3),
    .mem_we(mem_we3), .pc_sel(pc_sel3), .wb_sel(wb_sel3), .alu_src_imm(alu_src_imm3),
    .state(state3), .bus_err(bus_err3), .halted(halted3)
`ifdef CTRL_ILLEGAL_TRAP_EN
    , .trap(trap3)
`endif
  );

`ifndef CTRL_ILLEGAL_TRAP_EN
  assign trap15 = 1'b0;
  assign trap3  = 1'b0;
`endif

  obs_t o15, o3;
  always_comb begin
    o15 = '{pc_en15, ir_en15, ab_en15, aluo_en15, mdr_en15, rf_we15, mem_re15, mem_we15,
            pc_sel15, wb_sel15, alu_src_imm15, bus_err15, halted15, trap15, state15};
    o3  = '{pc_en3, ir_en3, ab_en3, aluo_en3, mdr_en3, rf_we3, mem_re3, mem_we3,
            pc_sel3, wb_sel3, alu_src_imm3, bus_err3, halted3, trap3, state3};
  end

  initial begin
    clk_n = 1'b1;
    forever #5 clk_n = ~clk_n;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int n_mdr15, n_rfwe15, n_memwe15, n_bus15, n_bus3, n_fen3, n_halt15, n_trap15;
  mdl_t m15, m3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Phase sequence of each instruction class.
  function automatic int route_ph(input int c, input int i);
    if (i == 0) return P_F;
    if (i == 1) return P_D;
    if (i == 2) return (c <= 5) ? P_E : ((c == 6) ? P_H : P_T);
    if (i == 3) return (c == 2 || c == 3) ? P_M : P_W;
    return P_W;
  endfunction

  function automatic int route_len(input int c);
    case (c)
      2:       return 5;
      4:       return 3;
      6:       return 3;
`ifdef CTRL_ILLEGAL_TRAP_EN
      7:       return 3;
`else
      7:       return 2;
`endif
      default: return 4;
    endcase
  endfunction

  function automatic void model_step(input mdl_t m, input int tmo, input logic [2:0] opc,
                                     input logic bt, input logic rdy, input logic rst,
                                     output obs_t e, output mdl_t nm);
    int ph;
    int c;
    bit waiting;
    bit abort;
    e  = '0;
    nm = m;
    if (!rst) begin
      nm = '{0, 0, 0};
      return;
    end
    ph      = route_ph(m.cls, m.idx);
    c       = (ph == P_D) ? int'(opc) : m.cls;
    waiting = (ph == P_F || ph == P_M) && !rdy;
    abort   = waiting && (tmo != 0) && (m.waits + 1 == tmo);
    e.state = 3'(ph);
    case (ph)
      P_F: begin
        e.mem_re = !abort;
        e.ir_en  = rdy;
        e.pc_en  = rdy;
      end
      P_D: e.ab_en = 1'b1;
      P_E: begin
        e.alu_src_imm = (c >= 1 && c <= 3);
        e.aluo_en     = (c <= 3);
        if (c == 4) begin e.pc_sel = 2'd1; e.pc_en = bt;   end
        if (c == 5) begin e.pc_sel = 2'd2; e.pc_en = 1'b1; end
      end
      P_M: begin
        if (c == 2) begin e.mem_re = !abort; e.mdr_en = rdy; end
        if (c == 3) e.mem_we = !abort;
      end
      P_W: begin
        e.rf_we  = 1'b1;
        e.wb_sel = (c == 2) ? 2'd1 : ((c == 5) ? 2'd2 : 2'd0);
      end
      P_H: e.halted = 1'b1;
      P_T: e.trap = 1'b1;
      default: ;
    endcase
    e.bus_err = abort;
    if (abort) begin
      nm.idx   = 0;
      nm.waits = 0;
    end else if (waiting) begin
      nm.waits = m.waits + 1;
    end else begin
      nm.waits = 0;
      nm.cls   = c;
      if (ph != P_H && ph != P_T) nm.idx = (m.idx + 1 < route_len(c)) ? m.idx + 1 : 0;
    end
  endfunction

  function automatic bit is_stuck(input mdl_t m);
    int ph;
    ph = route_ph(m.cls, m.idx);
    return (ph == P_H) || (ph == P_T);
  endfunction

  task automatic clear_tallies();
    n_mdr15 = 0; n_rfwe15 = 0; n_memwe15 = 0; n_bus15 = 0;
    n_bus3 = 0; n_fen3 = 0; n_halt15 = 0; n_trap15 = 0;
  endtask

  // Called just after a falling edge: drive, check mid-cycle, advance models.
  task automatic step(input logic [2:0] opc, input logic bt, input logic rdy, input logic rst);
    obs_t e15, e3;
    mdl_t n15, n3;
    op_class     = opc;
    branch_taken = bt;
    mem_ready    = rdy;
    rst_n        = rst;
    @(posedge clk_n);
    model_step(m15, 15, opc, bt, rdy, rst, e15, n15);
    model_step(m3, 3, opc, bt, rdy, rst, e3, n3);
    check("cycle_t15", {13'd0, o15}, {13'd0, e15});
    check("cycle_t3", {13'd0, o3}, {13'd0, e3});
    if (o15.mdr_en)  n_mdr15++;
    if (o15.rf_we)   n_rfwe15++;
    if (o15.mem_we)  n_memwe15++;
    if (o15.bus_err) n_bus15++;
    if (o15.halted)  n_halt15++;
    if (o15.trap)    n_trap15++;
    if (o3.bus_err)  n_bus3++;
    if (o3.ir_en || o3.pc_en) n_fen3++;
    m15 = n15;
    m3  = n3;
    @(negedge clk_n);
    #1;
  endtask

  // Runs one instruction from FETCH until the model is back at FETCH.
  task automatic run_instr(input logic [2:0] opc, input logic bt, input logic [31:0] lowmask,
                           input int exp_len, input string tag);
    int n;
    n = 0;
    do begin
      step(opc, bt, !lowmask[n], 1'b1);
      n++;
    end while (m15.idx != 0 && n < 30);
    check(tag, 32'(n), 32'(exp_len));
  endtask

  initial begin
    int burst;
    int stuck;
    rst_n        = 1'b0;
    op_class     = 3'd0;
    branch_taken = 1'b0;
    mem_ready    = 1'b0;
    m15 = '{0, 0, 0};
    m3  = '{0, 0, 0};
    clear_tallies();
    @(negedge clk_n);
    #1;

    step(3'd0, 1'b0, 1'b1, 1'b0);
    step(3'd2, 1'b1, 1'b1, 1'b0);

    clear_tallies();
    run_instr(3'd0, 1'b0, 32'h0, 4, "lat_alu_r");
    check("alu_r_rf_we_count", 32'(n_rfwe15), 32'd1);
    run_instr(3'd1, 1'b1, 32'h0, 4, "lat_alu_i");
    run_instr(3'd2, 1'b0, 32'h0, 5, "lat_load");
    run_instr(3'd3, 1'b0, 32'h0, 4, "lat_store");
    run_instr(3'd4, 1'b0, 32'h0, 3, "lat_branch_nt");
    run_instr(3'd4, 1'b1, 32'h0, 3, "lat_branch_t");
    run_instr(3'd5, 1'b0, 32'h0, 4, "lat_jump");

    clear_tallies();
    run_instr(3'd2, 1'b0, 32'h18, 7, "lat_load_2wait");
    check("load_mdr_en_count", 32'(n_mdr15), 32'd1);
    check("load_rf_we_count", 32'(n_rfwe15), 32'd1);

`ifndef CTRL_ILLEGAL_TRAP_EN
    clear_tallies();
    run_instr(3'd7, 1'b0, 32'h0, 2, "lat_illegal_nop");
    check("nop_write_strobes", 32'(n_rfwe15 + n_memwe15), 32'd0);
`endif

    clear_tallies();
    repeat (9) step(3'd0, 1'b0, 1'b0, 1'b1);
    check("t3_bus_err_count", 32'(n_bus3), 32'd3);
    check("t3_fetch_enables", 32'(n_fen3), 32'd0);
    check("t15_bus_err_count", 32'(n_bus15), 32'd0);

    clear_tallies();
    step(3'd6, 1'b0, 1'b1, 1'b1);
    step(3'd6, 1'b0, 1'b1, 1'b1);
    repeat (20) step(3'($urandom_range(0, 7)), 1'b1, 1'($urandom_range(0, 1)), 1'b1);
    check("halt_cycles", 32'(n_halt15), 32'd20);
    step(3'd0, 1'b0, 1'b1, 1'b0);

`ifdef CTRL_ILLEGAL_TRAP_EN
    clear_tallies();
    step(3'd7, 1'b0, 1'b1, 1'b1);
    step(3'd7, 1'b0, 1'b1, 1'b1);
    repeat (5) step(3'd0, 1'b0, 1'b1, 1'b1);
    check("trap_cycles", 32'(n_trap15), 32'd5);
    step(3'd0, 1'b0, 1'b1, 1'b0);
`endif

    burst = 0;
    stuck = 0;
    for (int i = 0; i < 2000; i++) begin
      logic [2:0] opc;
      logic       rdy;
      logic       rst;
      opc = 3'($urandom_range(0, 7));
      if (opc == 3'd6 && $urandom_range(0, 7) != 0) opc = 3'd0;
      if (burst > 0) begin
        rdy = 1'b0;
        burst--;
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 149) == 0) burst = 18;
      end
      stuck = (is_stuck(m15) || is_stuck(m3)) ? stuck + 1 : 0;
      rst   = !((stuck > 4) || ($urandom_range(0, 399) == 0));
      step(opc, 1'($urandom_range(0, 1)), rdy, rst);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
